// File: rtl/csdf_flux_phase_sched_pkg.sv
// Shared types and constants for the cyclo-static flux phase scheduler.
// Optional stall counter is enabled with CSDF_SCHED_STALL_CNT_EN.
package csdf_sched_pkg;

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Smallest r with 2**r >= v (v >= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csdf_flux_phase_sched_phase_ctr.sv
// Token/phase counter: counts RATE tokens per phase, then steps the
// phase pointer through 0..FLUX-1 with an explicit wrap.
module csdf_phase_ctr
    import csdf_sched_pkg::*;
#(
    parameter int FLUX = 2,
    parameter int RATE = 1,
    parameter int PH_W = 3
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            adv_i,
    output logic [PH_W-1:0] phase_o,
    output logic            last_o
);

    localparam int TOK_W = (RATE > 1) ? clog2(RATE) : 1;

    logic [TOK_W-1:0] tok_q;
    logic [TOK_W-1:0] tok_d;
    logic [PH_W-1:0]  ph_q;
    logic [PH_W-1:0]  ph_d;

    assign last_o  = (tok_q == TOK_W'(RATE - 1));
    assign phase_o = ph_q;

    // Advance the token count; on the last token move to the next phase.
    always_comb begin
        tok_d = tok_q;
        ph_d  = ph_q;
        if (adv_i) begin
            if (last_o) begin
                tok_d = '0;
                if (ph_q == PH_W'(FLUX - 1)) begin
                    ph_d = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end else begin
                tok_d = tok_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            tok_q <= '0;
            ph_q  <= '0;
        end else begin
            tok_q <= tok_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/csdf_flux_phase_sched.sv
// Cyclo-static phase scheduler: reads RATE tokens from each flux in turn
// and forwards them downstream. Stall counter: CSDF_SCHED_STALL_CNT_EN.
module csdf_flux_phase_sched
    import csdf_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    parameter int RATE  = 1,
    parameter int PH_W  = 3
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [FLUX-1:0]  flux_empty,
    output logic [FLUX-1:0]  flux_read,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_full,
    output logic             out_wr,
    output logic [WIDTH-1:0] out_data,
    output logic [PH_W-1:0]  phase
`ifdef CSDF_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             blank_q;
    logic [FLUX-1:0]  sel;
    logic             cur_empty;
    logic             rd;
    logic             wr;
    logic             last_unused;

    csdf_phase_ctr #(
        .FLUX (FLUX),
        .RATE (RATE),
        .PH_W (PH_W)
    ) u_ctr (
        .ck      (ck),
        .rst     (rst),
        .adv_i   (wr),
        .phase_o (phase),
        .last_o  (last_unused)
    );

    // One-hot decode of the phase pointer onto the flux lines.
    always_comb begin
        sel = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (phase == PH_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

    assign cur_empty = |(sel & flux_empty);

    // Read/write handshake; reads are blanked in and just after reset.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rd      = 1'b0;
        wr      = 1'b0;
        unique case (state_q)
            S_READ: begin
                rd = !cur_empty && !out_full && !blank_q && !rst;
                if (rd) begin
                    data_d  = in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr = !out_full && !rst;
                if (wr) begin
                    state_d = S_READ;
                end
            end
        endcase
    end

    assign flux_read = sel & {FLUX{rd}};
    assign out_wr    = wr;
    assign out_data  = data_q;

    // State, captured token and post-reset blanking flag.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= S_READ;
            data_q  <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            blank_q <= 1'b0;
        end
    end

`ifdef CSDF_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // Count cycles waiting on an empty flux or a full downstream.
    always_comb begin
        stall_d = stall_q;
        if (((state_q == S_READ) && cur_empty) ||
            ((state_q == S_WRITE) && out_full)) begin
            if (stall_q != STALL_MAX) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    // Saturating stall counter register.
    always_ff @(posedge ck) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
